// File: rtl/mem_stage.sv
// mem_stage
// ---------
// Memory-access pipeline stage sitting between execute and writeback.
// Holds one instruction from execute, waits for the data-memory response
// of loads/stores, aligns and extends load data, picks the final result
// (load data, timer value, mul/div result or ALU result) and hands the
// instruction on to writeback.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   es_to_ms_valid/bus  incoming instruction from execute
//   ms_allowin          this stage can accept an instruction
//   ws_allowin          writeback can accept an instruction
//   ms_to_ws_valid/bus  outgoing instruction to writeback
//   ms_forward          {valid, gr_we, dest, result, mem_pending, res_from_csr}
//                       forwarding/hazard information for decode
//   data_sram_data_ok   one response per issued data access
//   data_sram_rdata     load data, valid together with data_ok
//   mul_result          64-bit multiplier product
//   div_q, div_r        divider quotient and remainder
//   excp_flush          exception flush
//   ertn_flush          exception-return flush
//   ms_ex               the valid instruction held here carries an exception

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 218,
    parameter int MS_TO_WS_BUS_WD = 168,
    parameter int MS_FORWARD_WD   = 41,
    parameter int DISCARD_W       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic [63:0]                mul_result,
    input  logic [31:0]                div_q,
    input  logic [31:0]                div_r,
    input  logic                       excp_flush,
    input  logic                       ertn_flush,
    output logic                       ms_ex
);

    // The named fields occupy the low 217 bits of the incoming bus.
    localparam int FIELDS_WD = 217;
    localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic                       data_buf_valid;
    logic [31:0]                data_buf;
    logic [DISCARD_W-1:0]       discard_cnt;

    logic [31:0] pc;
    logic        ld_b, ld_h, ld_w, st_b, st_h, st_w, ld_bu, ld_hu;
    logic        ertn;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_cnt, res_from_mem, res_from_csr;
    logic [1:0]  addr_lo2;
    logic [3:0]  mul_div_op;
    logic        mul_div_sign;
    logic [31:0] alu_result, timer_value;
    logic        excp;
    logic [15:0] excp_num;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wdata;

    assign {pc, ld_b, ld_h, ld_w, st_b, st_h, st_w, ld_bu, ld_hu, ertn, dest,
            gr_we, res_from_cnt, res_from_mem, res_from_csr, addr_lo2,
            mul_div_op, mul_div_sign, alu_result, timer_value, excp, excp_num,
            csr_we, csr_num, csr_wmask, csr_wdata} = bus_r[FIELDS_WD-1:0];

    logic flush;
    logic need_resp;
    logic resp_ok;
    logic ms_ready_go;
    logic ms_leave;
    logic mem_pending;
    logic discard_inc;
    logic discard_dec;

    assign flush       = excp_flush | ertn_flush;
    // An excepting instruction never issued its request, so nothing to wait for.
    assign need_resp   = (ld_b | ld_h | ld_w | st_b | st_h | st_w | ld_bu | ld_hu) & ~excp;
    // Responses still owed to flushed instructions are not ours.
    assign resp_ok     = data_sram_data_ok & (discard_cnt == '0);
    assign ms_ready_go = ~flush & (~need_resp | data_buf_valid | resp_ok);
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin) | flush;
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign ms_leave    = ms_to_ws_valid & ws_allowin;
    assign mem_pending = need_resp & ~data_buf_valid & ~resp_ok;

    assign discard_inc = flush & ms_valid & need_resp & ~data_buf_valid & ~resp_ok;
    assign discard_dec = data_sram_data_ok & (discard_cnt != '0);

    // Stage valid bit and payload register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid & ms_allowin) begin
                bus_r <= es_to_ms_bus;
            end
        end
    end

    // Holds a response that arrived while writeback was stalled, since the
    // memory only presents rdata for the single data_ok cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_buf_valid <= 1'b0;
            data_buf       <= '0;
        end else if (ms_leave | flush) begin
            data_buf_valid <= 1'b0;
        end else if (ms_valid & need_resp & resp_ok & ~data_buf_valid &
                     ~(ms_ready_go & ws_allowin)) begin
            data_buf_valid <= 1'b1;
            data_buf       <= data_sram_rdata;
        end
    end

    // Counts responses still in flight for instructions killed by a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard_inc & ~discard_dec) begin
            if (discard_cnt != DISCARD_MAX) begin
                discard_cnt <= discard_cnt + 1'b1;
            end
        end else if (discard_dec & ~discard_inc) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    // Load alignment and extension.
    logic [31:0] mem_word;
    logic [7:0]  mem_byte;
    logic [15:0] mem_half;
    logic [31:0] load_result;

    assign mem_word = data_buf_valid ? data_buf : data_sram_rdata;
    assign mem_half = addr_lo2[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        mem_byte = mem_word[7:0];
        case (addr_lo2)
            2'd0: mem_byte = mem_word[7:0];
            2'd1: mem_byte = mem_word[15:8];
            2'd2: mem_byte = mem_word[23:16];
            2'd3: mem_byte = mem_word[31:24];
            default: mem_byte = mem_word[7:0];
        endcase
    end

    always_comb begin
        load_result = mem_word;
        if (ld_b) begin
            load_result = {{24{mem_byte[7]}}, mem_byte};
        end else if (ld_bu) begin
            load_result = {24'b0, mem_byte};
        end else if (ld_h) begin
            load_result = {{16{mem_half[15]}}, mem_half};
        end else if (ld_hu) begin
            load_result = {16'b0, mem_half};
        end
    end

    // Multiply/divide result selection and final result priority.
    logic [31:0] mul_div_result;
    logic [31:0] final_result;

    always_comb begin
        mul_div_result = 32'b0;
        if (mul_div_op[0]) begin
            mul_div_result = mul_result[31:0];
        end else if (mul_div_op[1]) begin
            mul_div_result = mul_result[63:32];
        end else if (mul_div_op[2]) begin
            mul_div_result = div_q;
        end else if (mul_div_op[3]) begin
            mul_div_result = div_r;
        end
    end

    always_comb begin
        final_result = alu_result;
        if (res_from_mem) begin
            final_result = load_result;
        end else if (res_from_cnt) begin
            final_result = timer_value;
        end else if (mul_div_op != 4'b0) begin
            final_result = mul_div_result;
        end
    end

    assign ms_to_ws_bus = {pc, ertn, dest, gr_we, res_from_csr, final_result,
                           excp, excp_num, csr_we, csr_num, csr_wmask, csr_wdata};

    assign ms_forward = {ms_valid, gr_we, dest, final_result, mem_pending, res_from_csr};

    assign ms_ex = ms_valid & excp;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// ------------
// Directed bench for mem_stage: load alignment/extension, response
// buffering under writeback stall, stale-response discard after a flush,
// mul/div/timer/alu result selection, exception status and reset.

module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic [217:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic [40:0]  ms_forward;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [63:0]  mul_result;
    logic [31:0]  div_q;
    logic [31:0]  div_r;
    logic         excp_flush;
    logic         ertn_flush;
    logic         ms_ex;

    int n_checks = 0;
    int n_fail   = 0;

    // Load/store flag patterns {ld_b, ld_h, ld_w, st_b, st_h, st_w, ld_bu, ld_hu}
    localparam logic [7:0] LS_NONE = 8'b0000_0000;
    localparam logic [7:0] LS_LDB  = 8'b1000_0000;
    localparam logic [7:0] LS_LDW  = 8'b0010_0000;
    localparam logic [7:0] LS_STW  = 8'b0000_0100;
    localparam logic [7:0] LS_LDBU = 8'b0000_0010;
    localparam logic [7:0] LS_LDHU = 8'b0000_0001;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mul_result        (mul_result),
        .div_q             (div_q),
        .div_r             (div_r),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .ms_ex             (ms_ex)
    );

    always #5 clk = ~clk;

    // Builds an execute payload; dest=7, gr_we=1, CSR fields zero.
    function automatic logic [217:0] mk_bus(input logic [31:0] pc,
                                            input logic [7:0]  ls,
                                            input logic [1:0]  lo2,
                                            input logic [3:0]  op,
                                            input logic        from_mem,
                                            input logic        from_cnt,
                                            input logic [31:0] alu,
                                            input logic [31:0] timer,
                                            input logic        excp,
                                            input logic [15:0] excp_num);
        return {1'b0, pc, ls, 1'b0, 5'd7, 1'b1, from_cnt, from_mem, 1'b0, lo2,
                op, 1'b0, alu, timer, excp, excp_num, 1'b0, 14'h0, 32'h0, 32'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Presents one instruction for a single edge; returns in its first cycle here.
    task automatic applyStimulus(input logic [217:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        step();
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        mul_result        = 64'h1234_5678_9ABC_DEF0;
        div_q             = 32'h0000_0011;
        div_r             = 32'h0000_0022;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;

        step();
        step();
        checkOutput("rst_valid",   ms_to_ws_valid, 0);
        checkOutput("rst_bus",     ms_to_ws_bus[63:0], 0);
        checkOutput("rst_bus_pc",  ms_to_ws_bus[167:136], 0);
        checkOutput("rst_fwd",     ms_forward, 0);
        checkOutput("rst_ex",      ms_ex, 0);
        checkOutput("rst_allowin", ms_allowin, 1);
        reset = 1'b0;
        step();

        // ld_w, response one cycle after entry
        applyStimulus(mk_bus(32'h1C00_0010, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0));
        checkOutput("ldw_wait_valid",   ms_to_ws_valid, 0);
        checkOutput("ldw_wait_allowin", ms_allowin, 0);
        checkOutput("ldw_wait_pending", ms_forward[1], 1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        checkOutput("ldw_valid",  ms_to_ws_valid, 1);
        checkOutput("ldw_result", ms_to_ws_bus[127:96], 64'h80FF_1234);
        checkOutput("ldw_pc",     ms_to_ws_bus[167:136], 64'h1C00_0010);
        checkOutput("ldw_fwd",    ms_forward[40:34], 7'b11_00111);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checkOutput("ldw_gone", ms_to_ws_valid, 0);

        // sub-word loads, response in the entry cycle
        applyStimulus(mk_bus(32'h1C00_0020, LS_LDB, 2'd3, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h9A00_0000;
        #1;
        checkOutput("ldb_valid",  ms_to_ws_valid, 1);
        checkOutput("ldb_result", ms_to_ws_bus[127:96], 64'hFFFF_FF9A);
        step();
        data_sram_data_ok = 1'b0;
        applyStimulus(mk_bus(32'h1C00_0024, LS_LDBU, 2'd3, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        #1;
        checkOutput("ldbu_result", ms_to_ws_bus[127:96], 64'h0000_009A);
        step();
        data_sram_data_ok = 1'b0;
        applyStimulus(mk_bus(32'h1C00_0028, LS_LDHU, 2'd2, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        #1;
        checkOutput("ldhu_result", ms_to_ws_bus[127:96], 64'h0000_8001);
        step();
        data_sram_data_ok = 1'b0;

        // response buffered while writeback stalls
        ws_allowin = 1'b0;
        applyStimulus(mk_bus(32'h1C00_0030, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1122_3344;
        #1;
        checkOutput("buf_first", ms_to_ws_bus[127:96], 64'h1122_3344);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hBADB_ADBA;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("buf_valid",   ms_to_ws_valid, 1);
            checkOutput("buf_result",  ms_to_ws_bus[127:96], 64'h1122_3344);
            checkOutput("buf_pc",      ms_to_ws_bus[167:136], 64'h1C00_0030);
            checkOutput("buf_allowin", ms_allowin, 0);
            checkOutput("buf_pending", ms_forward[1], 0);
            step();
        end
        ws_allowin = 1'b1;
        #1;
        checkOutput("buf_release", ms_allowin, 1);
        step();
        checkOutput("buf_gone", ms_to_ws_valid, 0);

        // flush while waiting; stale response must be dropped
        applyStimulus(mk_bus(32'h1C00_0040, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0));
        excp_flush = 1'b1;
        #1;
        checkOutput("flush_valid",   ms_to_ws_valid, 0);
        checkOutput("flush_allowin", ms_allowin, 1);
        step();
        excp_flush = 1'b0;
        checkOutput("flush_msvalid", ms_forward[40], 0);
        checkOutput("flush_cnt",     dut.discard_cnt, 1);
        applyStimulus(mk_bus(32'h1C00_0044, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        checkOutput("stale_dropped", ms_to_ws_valid, 0);
        checkOutput("stale_pending", ms_forward[1], 1);
        step();
        checkOutput("stale_cnt", dut.discard_cnt, 0);
        data_sram_rdata = 32'hCAFE_0001;
        #1;
        checkOutput("own_valid",  ms_to_ws_valid, 1);
        checkOutput("own_result", ms_to_ws_bus[127:96], 64'hCAFE_0001);
        step();
        data_sram_data_ok = 1'b0;

        // result selection without memory access
        applyStimulus(mk_bus(32'h1C00_0050, LS_NONE, 2'd0, 4'b0010, 0, 0, 32'h1, 0, 0, 0));
        checkOutput("mulh_valid",  ms_to_ws_valid, 1);
        checkOutput("mulh_result", ms_to_ws_bus[127:96], 64'h1234_5678);
        step();
        applyStimulus(mk_bus(32'h1C00_0054, LS_NONE, 2'd0, 4'b0001, 0, 0, 32'h1, 0, 0, 0));
        checkOutput("mull_result", ms_to_ws_bus[127:96], 64'h9ABC_DEF0);
        step();
        applyStimulus(mk_bus(32'h1C00_0058, LS_NONE, 2'd0, 4'b1000, 0, 0, 32'h1, 0, 0, 0));
        checkOutput("divr_result", ms_to_ws_bus[127:96], 64'h22);
        step();
        applyStimulus(mk_bus(32'h1C00_005C, LS_NONE, 2'd0, 4'b0100, 0, 1, 32'h1, 32'hABCD, 0, 0));
        checkOutput("cnt_result", ms_to_ws_bus[127:96], 64'hABCD);
        step();
        applyStimulus(mk_bus(32'h1C00_0060, LS_NONE, 2'd0, 4'b0000, 0, 0, 32'h1357_9BDF, 0, 0, 0));
        checkOutput("alu_result", ms_to_ws_bus[127:96], 64'h1357_9BDF);
        step();

        // excepting load does not wait
        applyStimulus(mk_bus(32'h1C00_0070, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 1, 16'h1234));
        checkOutput("ex_flag",  ms_ex, 1);
        checkOutput("ex_valid", ms_to_ws_valid, 1);
        checkOutput("ex_bus",   ms_to_ws_bus[95:79], 64'h1_1234);
        step();
        checkOutput("ex_gone", ms_ex, 0);

        // reset during an outstanding store with a pending discard
        applyStimulus(mk_bus(32'h1C00_0080, LS_STW, 2'd0, 4'h0, 0, 0, 0, 0, 0, 0));
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        applyStimulus(mk_bus(32'h1C00_0084, LS_STW, 2'd0, 4'h0, 0, 0, 0, 0, 0, 0));
        checkOutput("st_held", ms_forward[40], 1);
        checkOutput("st_cnt",  dut.discard_cnt, 1);
        reset = 1'b1;
        step();
        checkOutput("mid_rst_valid", ms_to_ws_valid, 0);
        checkOutput("mid_rst_bus",   ms_to_ws_bus[167:104], 0);
        checkOutput("mid_rst_fwd",   ms_forward, 0);
        checkOutput("mid_rst_ex",    ms_ex, 0);
        checkOutput("mid_rst_cnt",   dut.discard_cnt, 0);
        reset = 1'b0;
        step();
        applyStimulus(mk_bus(32'h1C00_0090, LS_LDW, 2'd0, 4'h0, 1, 0, 0, 0, 0, 0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55AA_55AA;
        #1;
        checkOutput("post_rst_valid",  ms_to_ws_valid, 1);
        checkOutput("post_rst_result", ms_to_ws_bus[127:96], 64'h55AA_55AA);
        step();
        data_sram_data_ok = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
